// File: rtl/req_lane_shaper_pkg.sv
// req_lane_shaper_pkg: lane state encoding and requester count shared by the shaper.
package req_lane_shaper_pkg;
   localparam int N_REQ = 3;
   typedef enum logic [2:0] {IDLE, REQ, SERV, REL, HOLD} lane_state_e;
endpackage

// File: rtl/req_lane_shaper_lane.sv
// req_lane: one requester lane turning job pulses into a request level held for SVC_CYCLES grants per job.
module req_lane
   import req_lane_shaper_pkg::*;
#(
   parameter int CNT_W      = 3,
   parameter int SVC_CYCLES = 4,
   parameter int HOLDOFF    = 1
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        req_pulse_i,
   input  logic        g_i,
   output logic        r_o,
   output logic        done_o,
   output logic        drop_o,
   output lane_state_e state_o
);
   localparam int SW = SVC_CYCLES > 1 ? $clog2(SVC_CYCLES) : 1;
   localparam int HW = HOLDOFF > 1 ? $clog2(HOLDOFF) : 1;
   localparam logic [SW-1:0] S_LAST = SW'(SVC_CYCLES - 1);
   localparam logic [HW-1:0] H_LAST = HW'(HOLDOFF > 0 ? HOLDOFF - 1 : 0);
   localparam logic [CNT_W-1:0] P_MAX = '1;
   lane_state_e state_q, state_d;
   logic [CNT_W-1:0] pend_q, pend_d;
   logic [SW-1:0] scnt_q, scnt_d;
   logic [HW-1:0] hcnt_q, hcnt_d;
   logic done_q, drop_q, cmpl, full;
   assign cmpl = state_q == SERV && g_i && scnt_q == S_LAST;
   assign full = pend_q == P_MAX;
   always_comb begin
      pend_d  = req_pulse_i && !cmpl && !full ? pend_q + 1'b1 :
                !req_pulse_i && cmpl ? pend_q - 1'b1 : pend_q;
      state_d = state_q;
      scnt_d  = scnt_q;
      hcnt_d  = hcnt_q;
      case (state_q)
         IDLE: if (pend_d != '0) state_d = REQ;
         REQ: if (g_i) begin
            state_d = SERV;
            scnt_d  = '0;
         end
         SERV: if (!g_i) begin
            state_d = REQ;
            scnt_d  = '0;
         end else if (cmpl) state_d = REL;
         else scnt_d = scnt_q + 1'b1;
         REL: if (!g_i) begin
            hcnt_d  = '0;
            state_d = HOLDOFF > 0 ? HOLD : pend_d != '0 ? REQ : IDLE;
         end
         HOLD: if (hcnt_q == H_LAST) state_d = pend_d != '0 ? REQ : IDLE;
         else hcnt_d = hcnt_q + 1'b1;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         state_q <= IDLE;
         pend_q  <= '0;
         scnt_q  <= '0;
         hcnt_q  <= '0;
         done_q  <= 1'b0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         scnt_q  <= scnt_d;
         hcnt_q  <= hcnt_d;
         done_q  <= cmpl;
         drop_q  <= req_pulse_i && !cmpl && full;
      end
   assign r_o     = state_q == REQ || state_q == SERV;
   assign done_o  = done_q;
   assign drop_o  = drop_q;
   assign state_o = state_q;
endmodule

// File: rtl/req_lane_shaper.sv
// req_lane_shaper: three independent request lanes feeding the priority arbiter, plus a sticky grant-protocol error flag.
module req_lane_shaper
   import req_lane_shaper_pkg::*;
#(
   parameter int CNT_W      = 3,
   parameter int SVC_CYCLES = 4,
   parameter int HOLDOFF    = 1
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic [N_REQ:1]   req_pulse,
   input  logic [N_REQ:1]   g,
   output logic [N_REQ:1]   r,
   output logic [N_REQ:1]   done,
   output logic [N_REQ:1]   drop,
   output logic             err
);
   lane_state_e st [N_REQ:1];
   logic [N_REQ:1] serv, bad;
   logic err_q;
   for (genvar i = 1; i <= N_REQ; i++) begin : g_lane
      req_lane #(.CNT_W(CNT_W), .SVC_CYCLES(SVC_CYCLES), .HOLDOFF(HOLDOFF)) u_lane (
         .clk         (clk),
         .resetn      (resetn),
         .req_pulse_i (req_pulse[i]),
         .g_i         (g[i]),
         .r_o         (r[i]),
         .done_o      (done[i]),
         .drop_o      (drop[i]),
         .state_o     (st[i])
      );
      assign serv[i] = st[i] == SERV;
      // a grant reaching a waiting lane while another lane is mid-service means the arbiter broke its hold
      assign bad[i]  = g[i] && (st[i] == IDLE || st[i] == HOLD ||
                       (st[i] == REQ && (serv & ~(N_REQ'(1) << (i - 1))) != '0));
   end
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) err_q <= 1'b0;
      else err_q <= err_q || ((g & (g - 1'b1)) != '0) || (|bad);
   assign err = err_q;
endmodule

// File: tb/tb_req_lane_shaper.sv
// tb_req_lane_shaper: directed checks of the lane shaper wired to a registered 3-way hold-while-requested arbiter model.
module tb_req_lane_shaper;
   logic clk = 1'b0, resetn = 1'b0, force_en = 1'b0, err;
   logic [3:1] req_pulse = '0, g_force = '0, g_arb, g, r, done, drop;
   int checks = 0, errors = 0, r1_cnt = 0, multi_cnt = 0;
   int done_cnt [1:3] = '{0, 0, 0};
   int drop_cnt [1:3] = '{0, 0, 0};
   int order [$];
   int b1, b2, b3, d2, d3, rb, ob, mb;

   req_lane_shaper #(.CNT_W(3), .SVC_CYCLES(4), .HOLDOFF(1)) dut (
      .clk(clk), .resetn(resetn), .req_pulse(req_pulse), .g(g),
      .r(r), .done(done), .drop(drop), .err(err)
   );

   always #5 clk = ~clk;

   always @(posedge clk or negedge resetn)
      if (!resetn) g_arb <= '0;
      else if (g_arb != '0) g_arb <= (g_arb & r) != '0 ? g_arb : 3'b000;
      else g_arb <= r[1] ? 3'b001 : r[2] ? 3'b010 : r[3] ? 3'b100 : 3'b000;
   assign g = force_en ? g_force : g_arb;

   always @(negedge clk) begin
      for (int i = 1; i <= 3; i++) begin
         if (done[i]) begin
            done_cnt[i]++;
            order.push_back(i);
         end
         if (drop[i]) drop_cnt[i]++;
      end
      if (r[1]) r1_cnt++;
      if ((g & (g - 3'd1)) != '0) multi_cnt++;
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_done(input int lane, input int target, input int budget);
      for (int k = 0; k < budget && done_cnt[lane] < target; k++) step(1);
   endtask

   initial begin
      #2;
      chk("rst_r", 8'(r), 8'h0);
      chk("rst_done", 8'(done), 8'h0);
      chk("rst_drop", 8'(drop), 8'h0);
      chk("rst_err", 8'(err), 8'h0);
      @(posedge clk);
      #1 resetn = 1'b1;
      step(2);

      b1 = done_cnt[1]; rb = r1_cnt;
      req_pulse = 3'b001; step(1); req_pulse = '0;
      chk("single_r_after_pulse", 8'(r), 8'h1);
      chk("single_g_not_yet", 8'(g), 8'h0);
      step(1);
      chk("single_g_granted", 8'(g), 8'h1);
      step(4);
      chk("single_r_last_serv", 8'(r), 8'h1);
      chk("single_done_early", 8'(done), 8'h0);
      step(1);
      chk("single_r_released", 8'(r), 8'h0);
      chk("single_done_pulse", 8'(done), 8'h1);
      step(1);
      chk("single_done_one_cycle", 8'(done), 8'h0);
      step(10);
      chk("single_r_idle", 8'(r), 8'h0);
      chk("single_done_count", 8'(done_cnt[1] - b1), 8'd1);
      chk("single_r_high_cycles", 8'(r1_cnt - rb), 8'd6);

      ob = order.size(); mb = multi_cnt;
      b1 = done_cnt[1]; b2 = done_cnt[2]; b3 = done_cnt[3];
      req_pulse = 3'b111; step(1); req_pulse = '0;
      chk("cont_r_all", 8'(r), 8'h7);
      wait_done(3, b3 + 1, 100);
      step(10);
      chk("cont_first", 8'(order[ob]), 8'd1);
      chk("cont_second", 8'(order[ob + 1]), 8'd2);
      chk("cont_third", 8'(order[ob + 2]), 8'd3);
      chk("cont_done1", 8'(done_cnt[1] - b1), 8'd1);
      chk("cont_done2", 8'(done_cnt[2] - b2), 8'd1);
      chk("cont_done3", 8'(done_cnt[3] - b3), 8'd1);
      chk("cont_multihot", 8'(multi_cnt - mb), 8'd0);
      chk("cont_err", 8'(err), 8'h0);
      chk("cont_r_idle", 8'(r), 8'h0);

      b2 = done_cnt[2]; d2 = drop_cnt[2];
      req_pulse = 3'b011; step(1); req_pulse = 3'b010;
      step(6);
      chk("sat_no_drop_at_7", 8'(drop), 8'h0);
      step(1); req_pulse = '0;
      chk("sat_drop_pulse", 8'(drop), 8'h2);
      chk("sat_lane2_waiting", 8'(r), 8'h2);
      step(1);
      chk("sat_drop_one_cycle", 8'(drop), 8'h0);
      wait_done(2, b2 + 7, 300);
      step(40);
      chk("sat_done2_count", 8'(done_cnt[2] - b2), 8'd7);
      chk("sat_drop2_count", 8'(drop_cnt[2] - d2), 8'd1);
      chk("sat_r_idle", 8'(r), 8'h0);
      chk("sat_err", 8'(err), 8'h0);

      b3 = done_cnt[3]; d3 = drop_cnt[3];
      req_pulse = 3'b100; step(1); req_pulse = '0;
      step(5);
      req_pulse = 3'b100; step(1); req_pulse = '0;
      chk("simul_done", 8'(done), 8'h4);
      chk("simul_no_drop", 8'(drop), 8'h0);
      chk("simul_rel_r", 8'(r), 8'h0);
      step(2);
      chk("simul_hold_r", 8'(r), 8'h0);
      step(1);
      chk("simul_rerequest", 8'(r), 8'h4);
      step(40);
      chk("simul_done3_count", 8'(done_cnt[3] - b3), 8'd2);
      chk("simul_drop3_count", 8'(drop_cnt[3] - d3), 8'd0);
      chk("simul_r_idle", 8'(r), 8'h0);

      b1 = done_cnt[1];
      req_pulse = 3'b001; step(1); req_pulse = '0;
      step(3);
      chk("mid_r_serving", 8'(r), 8'h1);
      #2 resetn = 1'b0;
      #1;
      chk("mid_r_async", 8'(r), 8'h0);
      chk("mid_done_async", 8'(done), 8'h0);
      chk("mid_drop_async", 8'(drop), 8'h0);
      step(2);
      resetn = 1'b1;
      step(20);
      chk("mid_r_after", 8'(r), 8'h0);
      chk("mid_no_done", 8'(done_cnt[1] - b1), 8'd0);

      chk("perr_clear", 8'(err), 8'h0);
      force_en = 1'b1; g_force = 3'b011;
      chk("perr_before_edge", 8'(err), 8'h0);
      step(1);
      force_en = 1'b0; g_force = '0;
      chk("perr_multihot_set", 8'(err), 8'h1);
      step(5);
      chk("perr_sticky", 8'(err), 8'h1);
      resetn = 1'b0;
      #1;
      chk("perr_reset_clears", 8'(err), 8'h0);
      step(1);
      resetn = 1'b1;
      step(1);
      force_en = 1'b1; g_force = 3'b001;
      step(1);
      force_en = 1'b0; g_force = '0;
      chk("perr_idle_grant_set", 8'(err), 8'h1);
      chk("perr_lane_unaffected", 8'(r), 8'h0);
      step(3);
      chk("perr_idle_sticky", 8'(err), 8'h1);
      resetn = 1'b0;
      #1;
      chk("perr_reset_again", 8'(err), 8'h0);
      resetn = 1'b1;
      step(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
